// File: rtl/dot_prod_pkg.sv
// Shared types and helpers for the multi-lane dot-product engine.
// Widths here are upper bounds; callers pass their real sizes.
package dot_prod_pkg;

   localparam int unsigned MaxLanes = 16;
   localparam int unsigned MaxAccW  = 128;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   typedef struct packed {
      logic [MaxAccW-1:0] value;
      logic               ovf;
   } sat_res_t;

   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Exact sum in MaxAccW bits, then range-checked against acc_w; the caller truncates to wrap.
   function automatic sat_res_t sat_add(input logic signed [MaxAccW-1:0] acc,
                                        input logic signed [MaxAccW-1:0] sum,
                                        input int unsigned               acc_w,
                                        input logic                      sat);
      logic signed [MaxAccW-1:0] full;
      logic signed [MaxAccW-1:0] max_v;
      logic signed [MaxAccW-1:0] min_v;
      sat_res_t                  res;
      full      = acc + sum;
      max_v     = $signed((MaxAccW'(1) << (acc_w - 1)) - MaxAccW'(1));
      min_v     = ~max_v;
      res.ovf   = (full > max_v) || (full < min_v);
      res.value = full;
      if (sat && res.ovf) begin
         res.value = (full > max_v) ? max_v : min_v;
      end
      return res;
   endfunction

   function automatic logic [MaxLanes-1:0] lane_mask(input int unsigned word,
                                                     input int unsigned lanes,
                                                     input int unsigned start,
                                                     input int unsigned stop);
      logic [MaxLanes-1:0] m;
      int unsigned         idx;
      m = '0;
      for (int unsigned l = 0; l < MaxLanes; l++) begin
         idx  = word * lanes + l;
         m[l] = (l < lanes) && (idx >= start) && (idx < stop);
      end
      return m;
   endfunction

endpackage

// File: rtl/dot_prod_lanes_bank.sv
// One memory bank: host owns the address/write port while host_sel is high,
// otherwise the engine address is used. Read data follows a registered address.
module dp_bank import dot_prod_pkg::*; #(
   parameter int unsigned DATA_W = 27,
   parameter int unsigned WORDS  = 256,
   localparam int unsigned WAW   = addr_w(WORDS)
) (
   input  logic              clk,
   input  logic              host_sel,
   input  logic              host_we,
   input  logic [WAW-1:0]    host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic [WAW-1:0]    eng_addr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [WORDS];
   logic [WAW-1:0]    addr_d, addr_q;

   always_comb begin
      addr_d = host_sel ? host_addr : eng_addr;
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      if (host_sel && host_we) begin
         mem_q[host_addr] <= host_wdata;
      end
   end

   assign rdata = mem_q[addr_q];

endmodule

// File: rtl/dot_prod_lanes.sv
// LANES-wide dot-product engine over banked a/b memories with a 3-stage
// read/multiply/accumulate pipeline, optional saturation and sticky flags.
module dot_prod_lanes import dot_prod_pkg::*; #(
   parameter int unsigned DATA_W = 27,
   parameter int unsigned ACC_W  = 64,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned LANES  = 4,
   parameter int unsigned SAT    = 0,
   localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r_enable,
   input  logic [ADDR_W-1:0] init_i,
   input  logic [ADDR_W:0]   init_len,
   input  logic [ACC_W-1:0]  init_acc,
   input  logic              controlArr,
   input  logic              controlArrWEnable_a,
   input  logic              controlArrWEnable_b,
   input  logic [ADDR_W-1:0] controlArrAddr_a,
   input  logic [ADDR_W-1:0] controlArrAddr_b,
   input  logic [DATA_W-1:0] controlArrWData_a,
   input  logic [DATA_W-1:0] controlArrWData_b,
   output logic [DATA_W-1:0] controlArrRData_a,
   output logic [DATA_W-1:0] controlArrRData_b,
   output logic              w_enable,
   output logic [ACC_W-1:0]  result,
   output logic              ovf,
   output logic              err
);

   localparam int unsigned AW1   = ADDR_W + 1;
   localparam int unsigned Words = DEPTH / LANES;
   localparam int unsigned WAW   = addr_w(Words);
   localparam int unsigned LB    = addr_w(LANES);
   localparam int unsigned PW    = 2 * DATA_W;
   localparam logic [ADDR_W-1:0] LanesA  = ADDR_W'(LANES);
   localparam logic [AW1-1:0]    LanesA1 = AW1'(LANES);
   localparam logic [AW1-1:0]    DepthA1 = AW1'(DEPTH);

   state_e                   state_q, state_d;
   logic [ADDR_W-1:0]        start_q, start_d;
   logic [AW1-1:0]           stop_q, stop_d, stop_new, last_elem;
   logic signed [ACC_W-1:0]  init_acc_q, init_acc_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d, result_q, result_d, lane_sum;
   logic [WAW-1:0]           word_q, word_d, last_q, last_d;
   logic [1:0]               drain_q, drain_d;
   logic                     v1_q, v1_d, v2_q, v2_d;
   logic [LANES-1:0]         mask1_q, mask1_d;
   logic [MaxLanes-1:0]      mask_full;
   logic signed [PW-1:0]     prod_q [LANES];
   logic signed [PW-1:0]     prod_d [LANES];
   logic                     w_enable_q, w_enable_d, ovf_q, ovf_d, err_q, err_d;
   sat_res_t                 sr;
   logic [LB-1:0]            rsel_a_q, rsel_a_d, rsel_b_q, rsel_b_d;
   logic [WAW-1:0]           hword_a, hword_b;
   logic signed [DATA_W-1:0] rd_a [LANES];
   logic signed [DATA_W-1:0] rd_b [LANES];
   logic                     unused_bits;

   // Element k lives in bank k % LANES at word k / LANES.
   always_comb begin
      rsel_a_d = LB'(controlArrAddr_a % LanesA);
      rsel_b_d = LB'(controlArrAddr_b % LanesA);
      hword_a  = WAW'(controlArrAddr_a / LanesA);
      hword_b  = WAW'(controlArrAddr_b / LanesA);
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      dp_bank #(
         .DATA_W (DATA_W),
         .WORDS  (Words)
      ) u_bank_a (
         .clk        (clk),
         .host_sel   (controlArr),
         .host_we    (controlArrWEnable_a && (rsel_a_d == LB'(i))),
         .host_addr  (hword_a),
         .host_wdata (controlArrWData_a),
         .eng_addr   (word_q),
         .rdata      (rd_a[i])
      );
      dp_bank #(
         .DATA_W (DATA_W),
         .WORDS  (Words)
      ) u_bank_b (
         .clk        (clk),
         .host_sel   (controlArr),
         .host_we    (controlArrWEnable_b && (rsel_b_d == LB'(i))),
         .host_addr  (hword_b),
         .host_wdata (controlArrWData_b),
         .eng_addr   (word_q),
         .rdata      (rd_b[i])
      );
   end

   always_comb begin
      stop_new  = {1'b0, init_i} + init_len;
      last_elem = stop_new - AW1'(1);
   end

   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      stop_d     = stop_q;
      init_acc_d = init_acc_q;
      word_d     = word_q;
      last_d     = last_q;
      drain_d    = drain_q;
      err_d      = err_q;
      ovf_d      = ovf_q;
      acc_d      = acc_q;

      mask_full = lane_mask(32'(word_q), LANES, 32'(start_q), 32'(stop_q));
      v1_d      = (state_q == ISSUE);
      mask1_d   = mask_full[LANES-1:0];
      v2_d      = v1_q;
      for (int l = 0; l < LANES; l++) begin
         prod_d[l] = mask1_q[l] ? PW'(rd_a[l]) * PW'(rd_b[l]) : '0;
      end

      lane_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_sum = lane_sum + ACC_W'(prod_q[l]);
      end
      sr = sat_add(MaxAccW'(acc_q), MaxAccW'(lane_sum), ACC_W, SAT != 0);
      if (v2_q) begin
         acc_d = sr.value[ACC_W-1:0];
         ovf_d = ovf_q | sr.ovf;
      end

      w_enable_d = (state_q == DONE);
      result_d   = (state_q == DONE) ? acc_q : result_q;

      case (state_q)
         ISSUE: begin
            if (word_q == last_q) begin
               state_d = DRAIN;
               drain_d = '0;
            end else begin
               word_d = word_q + WAW'(1);
            end
         end
         DRAIN: begin
            if (drain_q == 2'd2) begin
               state_d = DONE;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         default: ;
      endcase

      // Host grabbing the memories mid-run invalidates everything in flight.
      if (controlArr && (state_q == ISSUE || state_q == DRAIN)) begin
         state_d = DONE;
         err_d   = 1'b1;
         acc_d   = init_acc_q;
         v1_d    = 1'b0;
         v2_d    = 1'b0;
      end

      if (r_enable) begin
         start_d    = init_i;
         stop_d     = stop_new;
         init_acc_d = init_acc;
         acc_d      = init_acc;
         word_d     = WAW'(init_i / LanesA);
         last_d     = WAW'(last_elem / LanesA1);
         drain_d    = '0;
         w_enable_d = 1'b0;
         ovf_d      = 1'b0;
         err_d      = 1'b0;
         v1_d       = 1'b0;
         v2_d       = 1'b0;
         if (init_len == '0) begin
            state_d = DONE;
         end else if (stop_new > DepthA1) begin
            state_d = DONE;
            err_d   = 1'b1;
         end else begin
            state_d = ISSUE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         start_q    <= '0;
         stop_q     <= '0;
         init_acc_q <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         word_q     <= '0;
         last_q     <= '0;
         drain_q    <= '0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         mask1_q    <= '0;
         w_enable_q <= 1'b0;
         ovf_q      <= 1'b0;
         err_q      <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            prod_q[l] <= '0;
         end
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         init_acc_q <= init_acc_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         word_q     <= word_d;
         last_q     <= last_d;
         drain_q    <= drain_d;
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         mask1_q    <= mask1_d;
         w_enable_q <= w_enable_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
         for (int l = 0; l < LANES; l++) begin
            prod_q[l] <= prod_d[l];
         end
      end
   end

   always_ff @(posedge clk) begin
      rsel_a_q <= rsel_a_d;
      rsel_b_q <= rsel_b_d;
   end

   assign controlArrRData_a = rd_a[rsel_a_q];
   assign controlArrRData_b = rd_b[rsel_b_q];
   assign w_enable          = w_enable_q;
   assign result            = result_q;
   assign ovf               = ovf_q;
   assign err               = err_q;
   assign unused_bits       = ^{sr, mask_full};

endmodule
